// File: rtl/rom_read_master_if.sv
// Core-side request signals and ROM bus signals of rom_read_master.
// The master modport is the DUT, core is the fetch stage, and slave is the ROM responder.
interface rom_read_master_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // Handshakes:
  //  - Core side: req/req_addr are accepted on any rising edge where busy=0.
  //    ack is a one-cycle pulse; ack_data and err are valid while ack=1.
  //    ack_data then holds until the next ack.
  //  - Bus side: the transfer completes on the first edge in WAIT where rdy_n=0.
  //    rd_data is captured on that same edge.
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] ack_data;
  logic              err;
  logic              cs_n;
  logic              as_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_n;

  modport master (
    input  req, req_addr, rd_data, rdy_n,
    output busy, ack, ack_data, err, cs_n, as_n, addr
  );

  modport slave (
    input  cs_n, as_n, addr,
    output rd_data, rdy_n
  );

  modport core (
    output req, req_addr,
    input  busy, ack, ack_data, err
  );
endinterface

// File: rtl/rom_read_master.sv
// Single-word ROM read initiator: IDLE -> STROBE (1 cycle) -> WAIT until rdy_n=0, then ack.
// Define ROM_READ_MASTER_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with err=1.
module rom_read_master #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  rom_read_master_if.master   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cs_n_q, cs_n_d;
  logic              as_n_q, as_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] ack_data_q, ack_data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

`ifdef ROM_READ_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // TIMEOUT only shapes the optional abort path; nothing is built from it here.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cs_n_q     <= 1'b1;
      as_n_q     <= 1'b1;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      ack_data_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      as_n_q     <= as_n_d;
      addr_q     <= addr_d;
      ack_q      <= ack_d;
      ack_data_q <= ack_data_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are computed for the next state so every bus strobe comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = 1'b1;
    as_n_d     = 1'b1;
    addr_d     = addr_q;
    ack_d      = 1'b0;
    ack_data_d = ack_data_q;
    err_d      = 1'b0;
`ifdef ROM_READ_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_addr;
          state_d = S_STROBE;
          cs_n_d  = 1'b0;
          as_n_d  = 1'b0;
        end
      end
      S_STROBE: begin
        state_d = S_WAIT;
        cs_n_d  = 1'b0;
`ifdef ROM_READ_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        cs_n_d = 1'b0;
        if (!bus.rdy_n) begin
          ack_data_d = bus.rd_data;
          ack_d      = 1'b1;
          cs_n_d     = 1'b1;
          state_d    = S_IDLE;
        end
`ifdef ROM_READ_MASTER_TIMEOUT_EN
        // Abort on the edge where the counter would reach TIMEOUT; a ready on that edge wins.
        else if (cnt_q == CNT_LAST) begin
          cnt_d      = CNT_MAX;
          ack_data_d = '0;
          ack_d      = 1'b1;
          err_d      = 1'b1;
          cs_n_d     = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.as_n     = as_n_q;
  assign bus.addr     = addr_q;
  assign bus.ack      = ack_q;
  assign bus.ack_data = ack_data_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rom_read_master.sv
// Bench for rom_read_master: table of single reads against a behavioural ROM responder,
// plus back-to-back, ignored-request, idle-ready, reset-in-WAIT and optional timeout sequences.
module tb_rom_read_master;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  rom_read_master_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  rom_read_master #(.ADDR_W(11), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Responder controls, written only by the main sequence.
  int   extra_wait = 0;
  logic stuck = 1'b0;
  logic idle_rdy = 1'b0;
  logic mon_en = 1'b0;

  // Monitor results, written only by the monitor.
  int   ack_count = 0;
  logic saw_7ff = 1'b0;

  function automatic logic [31:0] rom_word(input logic [10:0] a);
    if (a == 11'h005) return 32'hDEADBEEF;
    return 32'h1000_0000 | {21'd0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM responder: ready in the cycle after the strobe, optionally delayed by extra_wait cycles.
  initial begin
    int dly;
    dly = 0;
    bus.rdy_n = 1'b1;
    bus.rd_data = '0;
    forever begin
      tick();
      if (idle_rdy && bus.cs_n === 1'b1) begin
        bus.rdy_n = 1'b0;
        bus.rd_data = 32'hBAD0BAD0;
      end else if (bus.cs_n === 1'b0 && bus.as_n === 1'b0) begin
        dly = extra_wait;
        bus.rdy_n = 1'b1;
      end else if (bus.cs_n === 1'b0 && !stuck && dly == 0) begin
        bus.rdy_n = 1'b0;
        bus.rd_data = rom_word(bus.addr);
      end else begin
        if (bus.cs_n === 1'b0 && dly > 0) dly--;
        bus.rdy_n = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.ack === 1'b1) ack_count++;
    if (!mon_en) saw_7ff = 1'b0;
    else if (bus.cs_n === 1'b0 && bus.addr === 11'h7FF) saw_7ff = 1'b1;
  end

  // Issues one read with the DUT idle; returns ack data/err, cycles from the request edge, protocol flag.
  task automatic do_read(input logic [10:0] a, input int extra, output logic [31:0] d,
                         output logic e, output int lat, output logic proto_ok);
    extra_wait = extra;
    bus.req = 1'b1;
    bus.req_addr = a;
    tick();
    bus.req = 1'b0;
    bus.req_addr = a ^ 11'h7FF;
    lat = 1;
    proto_ok = (bus.cs_n === 1'b0 && bus.as_n === 1'b0 && bus.addr === a && bus.busy === 1'b1);
    while (bus.ack !== 1'b1 && lat < 60) begin
      tick();
      lat++;
      if (bus.ack !== 1'b1)
        proto_ok &= (bus.cs_n === 1'b0 && bus.as_n === 1'b1 && bus.addr === a && bus.busy === 1'b1);
    end
    d = bus.ack_data;
    e = bus.err;
    if (bus.ack === 1'b1) proto_ok &= (bus.busy === 1'b0 && bus.cs_n === 1'b1);
  endtask

  typedef struct {
    logic [10:0] addr;
    int          extra;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [31:0] d;
    logic        e;
    int          lat;
    logic        ok;
    int          n;
    int          cyc;
    int          prev;
    int          acks0;

    vecs[0] = '{addr: 11'h005, extra: 0, exp_data: 32'hDEADBEEF, exp_lat: 3};
    vecs[1] = '{addr: 11'h7FF, extra: 0, exp_data: 32'h100007FF, exp_lat: 3};
    vecs[2] = '{addr: 11'h000, extra: 0, exp_data: 32'h10000000, exp_lat: 3};
    vecs[3] = '{addr: 11'h2AA, extra: 2, exp_data: 32'h100002AA, exp_lat: 5};
    vecs[4] = '{addr: 11'h155, extra: 4, exp_data: 32'h10000155, exp_lat: 7};

    bus.req = 1'b0;
    bus.req_addr = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {bus.cs_n, bus.as_n, bus.addr, bus.ack, bus.ack_data, bus.err, bus.busy, dbg_state},
          {1'b1, 1'b1, 11'h000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0});
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i].addr, vecs[i].extra, d, e, lat, ok);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), e, 1'b0);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_protocol", i), ok, 1'b1);
      tick();
      check($sformatf("vec%0d_ack_one_cycle", i), bus.ack, 1'b0);
    end

    // Back-to-back reads 0x000..0x00A, req held high so it is resampled in each ack cycle.
    extra_wait = 0;
    n = 0;
    cyc = 0;
    prev = 0;
    bus.req = 1'b1;
    bus.req_addr = 11'h000;
    while (n < 11 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.ack === 1'b1) begin
        check($sformatf("seq%0d_data", n), bus.ack_data, rom_word(11'(n)));
        check($sformatf("seq%0d_spacing", n), cyc - prev, 3);
        prev = cyc;
        n++;
        if (n < 11) bus.req_addr = 11'(n);
        else bus.req = 1'b0;
      end
    end
    check("seq_ack_count", n, 11);
    tick();

    // req with 0x7FF during WAIT of a read to 0x003 must be ignored.
    mon_en = 1'b1;
    extra_wait = 2;
    acks0 = ack_count;
    bus.req = 1'b1;
    bus.req_addr = 11'h003;
    tick();
    bus.req = 1'b0;
    tick();
    bus.req = 1'b1;
    bus.req_addr = 11'h7FF;
    tick();
    bus.req = 1'b0;
    cyc = 0;
    while (bus.ack !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("ignore_data", bus.ack_data, 32'h10000003);
    repeat (6) tick();
    check("ignore_ack_count", ack_count - acks0, 1);
    check("ignore_no_7ff_on_bus", saw_7ff, 1'b0);
    check("ignore_idle_after", bus.busy, 1'b0);
    mon_en = 1'b0;

    // rdy_n low while idle produces nothing.
    acks0 = ack_count;
    idle_rdy = 1'b1;
    repeat (5) tick();
    idle_rdy = 1'b0;
    tick();
    check("idle_rdy_no_ack", ack_count - acks0, 0);
    check("idle_rdy_not_busy", bus.busy, 1'b0);

    // Reset for one edge in the middle of WAIT.
    extra_wait = 6;
    bus.req = 1'b1;
    bus.req_addr = 11'h010;
    tick();
    bus.req = 1'b0;
    repeat (2) tick();
    check("pre_reset_in_wait", dbg_state, 2'd2);
    acks0 = ack_count;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_wait_reset_outputs",
          {bus.cs_n, bus.as_n, bus.addr, bus.ack, bus.ack_data, bus.err, bus.busy, dbg_state},
          {1'b1, 1'b1, 11'h000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0});
    repeat (8) tick();
    check("mid_wait_reset_no_ack", ack_count - acks0, 0);
    do_read(11'h001, 0, d, e, lat, ok);
    check("post_reset_data", d, 32'h10000001);
    check("post_reset_latency", lat, 3);
    check("post_reset_protocol", ok, 1'b1);
    tick();

`ifdef ROM_READ_MASTER_TIMEOUT_EN
    // rdy_n stuck high: 16 WAIT cycles (k+2..k+17), abort ack in k+18.
    stuck = 1'b1;
    do_read(11'h020, 0, d, e, lat, ok);
    stuck = 1'b0;
    check("timeout_err", e, 1'b1);
    check("timeout_data", d, 32'h0);
    check("timeout_latency", lat, 18);
    check("timeout_protocol", ok, 1'b1);
    tick();
    check("timeout_not_busy", bus.busy, 1'b0);
    do_read(11'h001, 0, d, e, lat, ok);
    check("after_timeout_data", d, 32'h10000001);
    check("after_timeout_err", e, 1'b0);
    check("after_timeout_latency", lat, 3);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rom_read_master.md
Name: rom_read_master

Overview:
- Bus initiator that issues single-word reads to the ROM bus responder over the cs_n/as_n/addr/rd_data/rdy_n protocol.
- Accepts a read from a simple core-side request interface and drives the bus strobes.
- Waits for the responder's ready, then returns the captured word with a one-cycle ack pulse.
- Sits between the instruction-fetch stage and the ROM.

Parameters:
- ADDR_W, 11, ROM word-address width (2048 words)
- DATA_W, 32, word data width
- TIMEOUT, 16, max WAIT cycles before abort (used only with ROM_READ_MASTER_TIMEOUT_EN)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  core read request, sampled only when busy=0
- req_addr  input  ADDR_W  word address for the request
- busy  output  1  high while a transaction is in flight (state != IDLE)
- ack  output  1  one-cycle pulse: read completed
- ack_data  output  DATA_W  read word; valid while ack=1, holds until next ack
- err  output  1  qualified by ack: 1 = timeout abort
- cs_n  output  1  bus chip select, active low
- as_n  output  1  bus address strobe, active low
- addr  output  ADDR_W  bus address
- rd_data  input  DATA_W  bus read data from responder
- rdy_n  input  1  bus ready, active low

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1, as_n=1, addr=0, ack=0, ack_data=0, err=0, busy=0, state=IDLE, wait counter=0.
- State IDLE:
  - cs_n=as_n=1.
  - If req=1 at edge k, latch req_addr into addr, go to STROBE.
- State STROBE (cycle k+1):
  - cs_n=0, as_n=0, addr stable.
  - Exactly one cycle, then WAIT; rdy_n is ignored in STROBE.
- State WAIT (cycle k+2 onward):
  - cs_n=0, as_n=1, addr held.
  - rdy_n sampled every edge.
  - On rdy_n=0: capture rd_data into ack_data; next cycle ack=1, err=0, cs_n=1, state=IDLE.
- Latency with a responder that drives rdy_n low in the cycle after the strobe: ack asserts in cycle k+3, i.e. 3 cycles from request edge.
- ack is high for exactly one cycle, with busy=0 in that cycle.
- A new req may be sampled at the end of the ack cycle, giving back-to-back issue every 3 cycles.
- req while busy=1 is ignored: not queued, no effect on the in-flight addr.
- req_addr changing after acceptance has no effect.
- rdy_n=0 while in IDLE: ignored, no ack.
- Reset asserted in any state (including mid-WAIT) returns to reset values on that edge.
  - No ack is produced for the aborted read.
  - cs_n deasserts the next cycle.
- Wait counter: cleared on entry to WAIT, incremented each WAIT cycle with rdy_n=1, saturates at TIMEOUT.

Optional Feature:
- Macro ROM_READ_MASTER_TIMEOUT_EN.
- Defined:
  - If the counter reaches TIMEOUT with rdy_n still 1, abort.
  - Next cycle: ack=1, err=1, ack_data=0, cs_n=1, state=IDLE.
  - If rdy_n=0 on the same edge the counter reaches TIMEOUT, the successful read wins (err=0, data captured).
- Undefined:
  - WAIT is held indefinitely until rdy_n=0.
  - err is constant 0.
  - The counter is not synthesized.

Test Plan:
- Single read, ROM word 0x005=0xDEADBEEF, 1-cycle responder: req at edge k.
  - Expect cs_n/as_n low in k+1, as_n high/cs_n low in k+2.
  - Expect ack=1 with ack_data=0xDEADBEEF, err=0 in k+3.
- Sequential reads, addr 0x000..0x00A, req re-raised in each ack cycle:
  - 11 acks spaced exactly 3 cycles apart.
  - Data matches the loaded ROM image.
- req pulsed with addr 0x7FF during WAIT of a read to 0x003:
  - Only one ack, data of 0x003.
  - Bus addr never shows 0x7FF.
- Responder holding rdy_n high 4 extra WAIT cycles:
  - cs_n stays low, as_n high throughout.
  - ack arrives at k+7 with correct data.
- ROM_READ_MASTER_TIMEOUT_EN with TIMEOUT=16 and rdy_n stuck high:
  - ack=1, err=1, ack_data=0 after 16 WAIT cycles.
  - busy drops; a next read to 0x001 completes normally.
- reset pulsed for 1 cycle in WAIT:
  - All outputs return to reset values.
  - No ack.
  - A following read succeeds with 3-cycle latency.
